// File: rtl/tally_counter_nbit.sv
// Button-driven up/down tally counter: thermometer LED output plus binary count.
// Buttons are synchronised, then sampled once per internal tick so bounce is filtered.
module tally_counter_nbit #(
  parameter int N        = 15,
  parameter int W        = 4,
  parameter int TICK_DIV = 25,
  parameter int WRAP     = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         BTN_UP,
  input  logic         BTN_DN,
  input  logic         AUTO,
  input  logic         CLR,
  output logic [N-1:0] LED,
  output logic [W-1:0] COUNT,
  output logic         FULL,
  output logic         EMPTY,
  output logic         STEP
);

  localparam logic [W-1:0] CMAX = W'(N);

  logic [TICK_DIV-1:0] tick_q;
  logic [1:0]          up_sync_q, dn_sync_q;
  logic                up_q, dn_q;
  logic [W-1:0]        count_q, count_d;
  logic                step_q, step_d;
  logic                tick, up_s, dn_s, up_ev, dn_ev;

  assign tick = &tick_q;
  assign up_s = up_sync_q[1];
  assign dn_s = dn_sync_q[1];

  // AUTO turns every held tick into an event; otherwise only a new press counts.
  assign up_ev = tick & up_s & (AUTO | ~up_q);
  assign dn_ev = tick & dn_s & (AUTO | ~dn_q);

  always_comb begin
    count_d = count_q;
    if (up_ev && !dn_ev) begin
      if (count_q == CMAX) count_d = (WRAP != 0) ? '0 : CMAX;
      else                 count_d = count_q + W'(1);
    end else if (dn_ev && !up_ev) begin
      if (count_q == '0)   count_d = (WRAP != 0) ? CMAX : '0;
      else                 count_d = count_q - W'(1);
    end
    step_d = tick & (count_d != count_q);
    if (CLR) begin
      count_d = '0;
      step_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_q    <= '0;
      up_sync_q <= '0;
      dn_sync_q <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      count_q   <= '0;
      step_q    <= 1'b0;
    end else begin
      tick_q    <= tick_q + TICK_DIV'(1);
      up_sync_q <= {up_sync_q[0], BTN_UP};
      dn_sync_q <= {dn_sync_q[0], BTN_DN};
      if (tick) begin
        up_q <= up_s;
        dn_q <= dn_s;
      end
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) LED[i] = (int'(count_q) > i);
  end

  assign COUNT = count_q;
  assign FULL  = (count_q == CMAX);
  assign EMPTY = (count_q == '0);
  assign STEP  = step_q;

endmodule
